// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - staged peripheral/core reset release after a filtered PLL lock
module pll_reset_sequencer #(
  parameter int LOCK_FILTER    = 8,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int PERIPH_TO_CORE = 16,
  parameter int SOFT_HOLD      = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       soft_req,
  output logic       rst_periph,
  output logic       rst_core,
  output logic       ready,
  output logic [3:0] lock_loss_count,
  output logic [2:0] state
);

  localparam int MAX_AB  = (LOCK_FILTER > SETTLE_CYCLES) ? LOCK_FILTER : SETTLE_CYCLES;
  localparam int MAX_CD  = (PERIPH_TO_CORE > SOFT_HOLD) ? PERIPH_TO_CORE : SOFT_HOLD;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    PERIPH    = 3'd2,
    RUN       = 3'd3,
    SOFT      = 3'd4
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic [1:0]    rs;
  logic [1:0]    ls;
  logic          lock_s;

  assign lock_s = ls[1];
  assign state  = st;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rs <= 2'b00;
      ls <= 2'b00;
    end else begin
      rs <= {rs[0], 1'b1};
      ls <= {ls[0], pll_lock};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st              <= WAIT_LOCK;
      cnt             <= '0;
      rst_periph      <= 1'b1;
      rst_core        <= 1'b1;
      ready           <= 1'b0;
      lock_loss_count <= 4'd0;
    end else if (!rs[1]) begin
      st         <= WAIT_LOCK;
      cnt        <= '0;
      rst_periph <= 1'b1;
      rst_core   <= 1'b1;
      ready      <= 1'b0;
    end else if (st != WAIT_LOCK && !lock_s) begin
      // Lock loss outranks everything, including a pending soft request.
      st         <= WAIT_LOCK;
      cnt        <= '0;
      rst_periph <= 1'b1;
      rst_core   <= 1'b1;
      ready      <= 1'b0;
      if (st == RUN && lock_loss_count != 4'd15)
        lock_loss_count <= lock_loss_count + 4'd1;
    end else begin
      case (st)
        WAIT_LOCK: begin
          if (!lock_s) begin
            cnt <= '0;
          end else if (cnt == CW'(LOCK_FILTER - 1)) begin
            st  <= SETTLE;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            st         <= PERIPH;
            cnt        <= '0;
            rst_periph <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PERIPH: begin
          if (cnt == CW'(PERIPH_TO_CORE - 1)) begin
            st       <= RUN;
            cnt      <= '0;
            rst_core <= 1'b0;
            ready    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (soft_req) begin
            st         <= SOFT;
            cnt        <= '0;
            rst_periph <= 1'b1;
            rst_core   <= 1'b1;
            ready      <= 1'b0;
          end
        end
        SOFT: begin
          // Lock is still good, so skip re-filtering and settling.
          if (cnt == CW'(SOFT_HOLD - 1)) begin
            st         <= PERIPH;
            cnt        <= '0;
            rst_periph <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          st         <= WAIT_LOCK;
          cnt        <= '0;
          rst_periph <= 1'b1;
          rst_core   <= 1'b1;
          ready      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       soft_req;
  logic       rst_periph;
  logic       rst_core;
  logic       ready;
  logic [3:0] lock_loss_count;
  logic [2:0] state;

  typedef struct {
    int         edge_n;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ecount = 0;

  localparam logic [9:0] RST_V = {3'd0, 1'b1, 1'b1, 1'b0, 4'd0};

  pll_reset_sequencer dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pll_lock        (pll_lock),
    .soft_req        (soft_req),
    .rst_periph      (rst_periph),
    .rst_core        (rst_core),
    .ready           (ready),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] pk(input int st, input bit rp, input bit rc, input bit rdy, input int llc);
    return {3'(st), rp, rc, rdy, 4'(llc)};
  endfunction

  function automatic logic [9:0] snap();
    return {state, rst_periph, rst_core, ready, lock_loss_count};
  endfunction

  task automatic push(input int e, input logic [9:0] v);
    exp_t x;
    x.edge_n = e;
    x.v      = v;
    q.push_back(x);
  endtask

  task automatic goto(input int e);
    while (ecount < e) @(negedge clock);
  endtask

  // Monitor: every change of the output vector must match the next expected record.
  initial begin
    logic [9:0] prev;
    logic [9:0] cur;
    exp_t       x;
    prev = RST_V;
    forever begin
      @(posedge clock);
      ecount++;
      #1;
      cur = snap();
      if (cur != prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change edge=%0d actual=%h required=no change", ecount, cur);
        end else begin
          x = q.pop_front();
          if (x.edge_n != ecount || x.v != cur) begin
            errors++;
            $display("FAIL output_change actual edge=%0d val=%h required edge=%0d val=%h",
                     ecount, cur, x.edge_n, x.v);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic do_reset(input string name);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (snap() !== RST_V) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, snap(), RST_V);
    end
    push(ecount + 1, RST_V);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int b;
    int n;
    int e0;
    int l;
    int llc;
    reset_n  = 1'b0;
    pll_lock = 1'b1;
    soft_req = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (snap() !== RST_V) begin
      errors++;
      $display("FAIL reset_state actual=%h required=%h", snap(), RST_V);
    end

    // Cold start
    reset_n = 1'b1;
    b = ecount;
    push(b + 10,   pk(1, 1, 1, 0, 0));
    push(b + 1034, pk(2, 0, 1, 0, 0));
    push(b + 1050, pk(3, 0, 0, 1, 0));
    goto(b + 1052);

    // Single-cycle soft request
    n = ecount + 1;
    push(n,      pk(4, 1, 1, 0, 0));
    push(n + 4,  pk(2, 0, 1, 0, 0));
    push(n + 20, pk(3, 0, 0, 1, 0));
    soft_req = 1'b1;
    goto(n);
    soft_req = 1'b0;
    goto(n + 22);

    // Soft request held through SOFT and PERIPH re-triggers on first RUN cycle
    n = ecount + 1;
    push(n,      pk(4, 1, 1, 0, 0));
    push(n + 4,  pk(2, 0, 1, 0, 0));
    push(n + 20, pk(3, 0, 0, 1, 0));
    push(n + 21, pk(4, 1, 1, 0, 0));
    push(n + 25, pk(2, 0, 1, 0, 0));
    push(n + 41, pk(3, 0, 0, 1, 0));
    soft_req = 1'b1;
    goto(n + 21);
    soft_req = 1'b0;
    goto(n + 43);

    // Lock loss and soft request seen in the same RUN cycle
    e0 = ecount;
    l  = e0 + 3;
    push(l,        pk(0, 1, 1, 0, 1));
    push(l + 8,    pk(1, 1, 1, 0, 1));
    push(l + 1032, pk(2, 0, 1, 0, 1));
    push(l + 1048, pk(3, 0, 0, 1, 1));
    pll_lock = 1'b0;
    goto(e0 + 1);
    pll_lock = 1'b1;
    goto(e0 + 2);
    soft_req = 1'b1;
    goto(e0 + 3);
    soft_req = 1'b0;
    goto(l + 1050);

    // Reset from RUN, then a lock glitch after 5 WAIT_LOCK samples
    do_reset("reset_in_run");
    reset_n = 1'b1;
    b = ecount;
    push(b + 16,   pk(1, 1, 1, 0, 0));
    push(b + 1040, pk(2, 0, 1, 0, 0));
    push(b + 1056, pk(3, 0, 0, 1, 0));
    goto(b + 5);
    pll_lock = 1'b0;
    goto(b + 6);
    pll_lock = 1'b1;
    goto(b + 1058);

    // Repeated lock losses in RUN; count saturates at 15
    for (int i = 0; i < 20; i++) begin
      llc = (i + 1 > 15) ? 15 : i + 1;
      e0 = ecount;
      l  = e0 + 3;
      push(l,        pk(0, 1, 1, 0, llc));
      push(l + 8,    pk(1, 1, 1, 0, llc));
      push(l + 1032, pk(2, 0, 1, 0, llc));
      push(l + 1048, pk(3, 0, 0, 1, llc));
      pll_lock = 1'b0;
      goto(e0 + 1);
      pll_lock = 1'b1;
      goto(l + 1050);
    end

    // Reset mid-SETTLE clears the saturated count
    e0 = ecount;
    l  = e0 + 3;
    push(l,     pk(0, 1, 1, 0, 15));
    push(l + 8, pk(1, 1, 1, 0, 15));
    pll_lock = 1'b0;
    goto(e0 + 1);
    pll_lock = 1'b1;
    goto(l + 500);
    do_reset("reset_mid_settle");

    // Reset mid-PERIPH
    reset_n = 1'b1;
    b = ecount;
    push(b + 10,   pk(1, 1, 1, 0, 0));
    push(b + 1034, pk(2, 0, 1, 0, 0));
    goto(b + 1040);
    do_reset("reset_mid_periph");

    // Clean restart
    reset_n = 1'b1;
    b = ecount;
    push(b + 10,   pk(1, 1, 1, 0, 0));
    push(b + 1034, pk(2, 0, 1, 0, 0));
    push(b + 1050, pk(3, 0, 0, 1, 0));
    goto(b + 1052);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
